// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx framer: SOF default, FSM encoding, FIFO entry layout.
package uart_pkg;

   localparam logic [7:0] SOF_DEFAULT = 8'h7E;
   localparam int         ENTRY_W     = 9;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LAUNCH = 2'd1;
   localparam logic [1:0] ST_ACK    = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_LAUNCH = ST_LAUNCH,
      S_ACK    = ST_ACK,
      S_DONE   = ST_DONE
   } state_e;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } fifo_entry_t;

   function automatic fifo_entry_t make_entry(input logic last, input logic [7:0] data);
      fifo_entry_t e;
      e.last = last;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through FIFO with occupancy count; pointers wrap naturally (DEPTH is a power of 2).
module uart_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == {CW{1'b0}});
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Next-state pointer and occupancy arithmetic
   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/uart_tx_framer.sv
// Packet framer feeding uart_tx: SOF + payload (+ XOR checksum when UART_TX_CHECKSUM_EN is defined).
// Payload is buffered in a FWFT FIFO; the FSM drives the uart_tx start/data/busy handshake.
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int         FIFO_DEPTH  = 16,
   parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
   parameter int         ACK_TIMEOUT = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic                          tx_start,
   output logic [7:0]                    tx_data,
   input  logic                          tx_busy,
   output logic                          frame_active,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_err
);

   localparam int             AW       = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [AW-1:0]  ACK_LAST = AW'(ACK_TIMEOUT - 1);

   logic               fifo_full, fifo_empty, fifo_pop, fifo_push;
   logic [ENTRY_W-1:0] fifo_rdata;
   fifo_entry_t        head;

   state_e         state_q, state_d;
   logic           tx_start_q, tx_start_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           frame_active_q, frame_active_d;
   logic           tx_err_q, tx_err_d;
   logic           pend_q, pend_d;
   logic [AW-1:0]  ack_cnt_q, ack_cnt_d;
`ifdef UART_TX_CHECKSUM_EN
   logic [7:0]     csum_q, csum_d;
   logic           csum_sent_q, csum_sent_d;
`endif

   assign in_ready     = ~rst & ~fifo_full;
   assign fifo_push    = in_valid & in_ready;
   assign head         = fifo_entry_t'(fifo_rdata);
   assign tx_start     = tx_start_q;
   assign tx_data      = tx_data_q;
   assign frame_active = frame_active_q;
   assign tx_err       = tx_err_q;

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (make_entry(in_last, in_data)),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Framing FSM next-state and output selection
   always_comb begin
      state_d        = state_q;
      tx_start_d     = 1'b0;
      tx_data_d      = tx_data_q;
      frame_active_d = frame_active_q;
      tx_err_d       = tx_err_q;
      pend_d         = pend_q;
      ack_cnt_d      = ack_cnt_q;
      fifo_pop       = 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      csum_d         = csum_q;
      csum_sent_d    = csum_sent_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               tx_data_d      = SOF_BYTE;
               tx_start_d     = 1'b1;
               frame_active_d = 1'b1;
               pend_d         = 1'b1;
               ack_cnt_d      = {AW{1'b0}};
`ifdef UART_TX_CHECKSUM_EN
               csum_d         = 8'h00;
               csum_sent_d    = 1'b0;
`endif
               state_d        = S_LAUNCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            ack_cnt_d = ack_cnt_q + AW'(1);
            state_d   = S_ACK;
         end
         S_ACK: begin
            // A missing busy acknowledge is flagged, then the byte is treated as sent
            if (tx_busy) begin
               state_d = S_DONE;
            end else if (ack_cnt_q >= ACK_LAST) begin
               tx_err_d = 1'b1;
               state_d  = S_DONE;
            end else begin
               ack_cnt_d = ack_cnt_q + AW'(1);
            end
         end
         S_DONE: begin
            if (tx_busy) begin
               state_d = S_DONE;
            end else if (pend_q) begin
               if (!fifo_empty) begin
                  fifo_pop   = 1'b1;
                  tx_data_d  = head.data;
                  tx_start_d = 1'b1;
                  pend_d     = ~head.last;
                  ack_cnt_d  = {AW{1'b0}};
`ifdef UART_TX_CHECKSUM_EN
                  csum_d     = csum_q ^ head.data;
`endif
                  state_d    = S_LAUNCH;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
`ifdef UART_TX_CHECKSUM_EN
               if (!csum_sent_q) begin
                  tx_data_d   = csum_q;
                  tx_start_d  = 1'b1;
                  csum_sent_d = 1'b1;
                  ack_cnt_d   = {AW{1'b0}};
                  state_d     = S_LAUNCH;
               end else begin
                  frame_active_d = 1'b0;
                  state_d        = S_IDLE;
               end
`else
               frame_active_d = 1'b0;
               state_d        = S_IDLE;
`endif
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         tx_start_q     <= 1'b0;
         tx_data_q      <= 8'h00;
         frame_active_q <= 1'b0;
         tx_err_q       <= 1'b0;
         pend_q         <= 1'b0;
         ack_cnt_q      <= {AW{1'b0}};
`ifdef UART_TX_CHECKSUM_EN
         csum_q         <= 8'h00;
         csum_sent_q    <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
         frame_active_q <= frame_active_d;
         tx_err_q       <= tx_err_d;
         pend_q         <= pend_d;
         ack_cnt_q      <= ack_cnt_d;
`ifdef UART_TX_CHECKSUM_EN
         csum_q         <= csum_d;
         csum_sent_q    <= csum_sent_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: a behavioural uart_tx stand-in captures every launched byte and
// the captured stream is compared with frames built from packet contents (checksum per UART_TX_CHECKSUM_EN).
module tb_uart_tx_framer;

   localparam int DEPTH    = 16;
   localparam int ACK_TO   = 8;
   localparam int BUSY_LEN = 10;

   typedef logic [7:0] bq_t [$];

   logic       clk      = 1'b0;
   logic       rst      = 1'b1;
   logic [7:0] in_data  = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_last  = 1'b0;
   logic       tx_busy  = 1'b0;
   logic       in_ready, tx_start, frame_active, tx_err;
   logic [7:0] tx_data;
   logic [4:0] fifo_count;

   int   total = 0;
   int   bad   = 0;
   int   stub_mode = 0;   // 0: uart-like busy, 1: busy stuck high, 2: busy stuck low
   int   bcnt = 0;
   int   unstable = 0;
   int   dbl = 0;
   logic prev_start = 1'b0;
   logic [7:0] held = 8'h00;
   bq_t  cap;
   bq_t  exp;

   uart_tx_framer #(.FIFO_DEPTH(DEPTH), .SOF_BYTE(8'h7E), .ACK_TIMEOUT(ACK_TO)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
      .frame_active(frame_active), .fifo_count(fifo_count), .tx_err(tx_err)
   );

   always #10 clk = ~clk;

   // uart_tx stand-in: captures launched bytes, models busy, watches data stability and pulse width
   always @(posedge clk) begin
      prev_start <= tx_start;
      if (tx_start && prev_start) dbl <= dbl + 1;
      if (tx_start) cap.push_back(tx_data);
      if (rst) held <= 8'h00;
      else if (tx_start) held <= tx_data;
      else if (stub_mode == 0 && tx_busy && tx_data !== held) unstable <= unstable + 1;
      case (stub_mode)
         1: tx_busy <= 1'b1;
         2: tx_busy <= 1'b0;
         default: begin
            if (tx_start) begin
               tx_busy <= 1'b1;
               bcnt    <= BUSY_LEN;
            end else if (bcnt > 1) begin
               bcnt <= bcnt - 1;
            end else begin
               bcnt    <= 0;
               tx_busy <= 1'b0;
            end
         end
      endcase
   end

   // Reference frame: SOF, payload, optional XOR of payload
   function automatic void add_expected(input bq_t pkt);
      logic [7:0] x = 8'h00;
      exp.push_back(8'h7E);
      foreach (pkt[i]) begin
         exp.push_back(pkt[i]);
         x = x ^ pkt[i];
      end
`ifdef UART_TX_CHECKSUM_EN
      exp.push_back(x);
`endif
   endfunction

   function automatic int frame_diffs();
      int d = 0;
      if (cap.size() != exp.size()) d++;
      for (int i = 0; i < cap.size() && i < exp.size(); i++)
         if (cap[i] !== exp[i]) d++;
      return d;
   endfunction

   task automatic push_byte(input logic [7:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = l;
      #1;
      while (!in_ready && n < 2000) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 2000) begin
         total++; bad++;
         $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end
      @(posedge clk);
      #1 in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      int n = 0;
      ok = 1'b0;
      while (n < 5000) begin
         @(negedge clk); n++;
         if (!frame_active && fifo_count == 5'd0 && !tx_start && !tx_busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++; if (tx_start !== 1'b0)      begin bad++; $display("FAIL rst_tx_start got=%b want=0", tx_start); end
      total++; if (tx_data !== 8'h00)      begin bad++; $display("FAIL rst_tx_data got=%h want=00", tx_data); end
      total++; if (frame_active !== 1'b0)  begin bad++; $display("FAIL rst_frame_active got=%b want=0", frame_active); end
      total++; if (tx_err !== 1'b0)        begin bad++; $display("FAIL rst_tx_err got=%b want=0", tx_err); end
      total++; if (fifo_count !== 5'd0)    begin bad++; $display("FAIL rst_fifo_count got=%0d want=0", fifo_count); end
      total++; if (in_ready !== 1'b0)      begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
      rst = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1)      begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_single();
      bq_t pkt;
      int  n = 0;
      bit  seen = 1'b0;
      cap.delete(); exp.delete();
      pkt.push_back(8'hA5);
      add_expected(pkt);
      push_byte(8'hA5, 1'b1);
      while (n < 3000) begin
         @(negedge clk); n++;
         if (frame_active) seen = 1'b1;
         else if (seen) break;
      end
      total++; if (!(seen && !frame_active)) begin bad++; $display("FAIL single_fall: frame_active=%b seen=%b want fall", frame_active, seen); end
      total++; if (cap.size() != exp.size() || tx_busy !== 1'b0) begin bad++; $display("FAIL single_fall_timing: bytes=%0d busy=%b want bytes=%0d busy=0", cap.size(), tx_busy, exp.size()); end
      total++; if (frame_diffs() != 0) begin bad++; $display("FAIL single_frame: got %0d bytes, want %0d, diffs=%0d", cap.size(), exp.size(), frame_diffs()); end
   endtask

   task automatic test_back_to_back();
      bq_t pkt;
      bit  ok;
      cap.delete(); exp.delete(); dbl = 0; unstable = 0;
      for (int p = 0; p < 4; p++) begin
         int len = (p == 0) ? 3 : int'($urandom_range(1, 5));
         pkt.delete();
         for (int i = 0; i < len; i++) pkt.push_back((p == 0) ? 8'(i + 1) : 8'($urandom));
         add_expected(pkt);
         foreach (pkt[i]) push_byte(pkt[i], i == len - 1);
      end
      wait_idle(ok);
      total++; if (!ok)            begin bad++; $display("FAIL b2b_idle: frame not idle within bound, got=0 want=1"); end
      total++; if (frame_diffs() != 0) begin bad++; $display("FAIL b2b_frames: got %0d bytes, want %0d, diffs=%0d", cap.size(), exp.size(), frame_diffs()); end
      total++; if (dbl != 0 || unstable != 0) begin bad++; $display("FAIL b2b_handshake: wide_pulses=%0d data_changes=%0d want 0/0", dbl, unstable); end
   endtask

   task automatic test_full();
      bq_t pkt;
      int  acc = 0;
      bit  ok;
      cap.delete(); exp.delete();
      stub_mode = 1;
      for (int i = 0; i < 20; i++) begin
         logic [7:0] d = 8'($urandom);
         @(negedge clk);
         in_valid = 1'b1; in_data = d; in_last = (i == 15);
         #1;
         if (in_ready) begin acc++; pkt.push_back(d); end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      total++; if (acc != DEPTH)       begin bad++; $display("FAIL full_accepts got=%0d want=%0d", acc, DEPTH); end
      total++; if (fifo_count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d want=16", fifo_count); end
      total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
      add_expected(pkt);
      stub_mode = 0;
      wait_idle(ok);
      total++; if (!ok || frame_diffs() != 0) begin bad++; $display("FAIL full_drain: idle=%b got %0d bytes want %0d diffs=%0d", ok, cap.size(), exp.size(), frame_diffs()); end
   endtask

   task automatic test_timeout();
      bq_t pkt;
      int  n = 0;
      bit  ok;
      cap.delete(); exp.delete();
      stub_mode = 2;
      pkt.push_back(8'h55);
      add_expected(pkt);
      push_byte(8'h55, 1'b1);
      while (!tx_start && n < 100) begin @(negedge clk); n++; end
      total++; if (!tx_start) begin bad++; $display("FAIL to_start: tx_start got=0 want=1"); end
      for (int k = 1; k <= ACK_TO; k++) begin
         @(negedge clk);
         if (k == ACK_TO - 1) begin
            total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL to_early got=%b want=0", tx_err); end
         end
         if (k == ACK_TO) begin
            total++; if (tx_err !== 1'b1) begin bad++; $display("FAIL to_set got=%b want=1", tx_err); end
         end
      end
      wait_idle(ok);
      total++; if (!ok || frame_diffs() != 0) begin bad++; $display("FAIL to_frame: idle=%b got %0d bytes want %0d", ok, cap.size(), exp.size()); end
      repeat (20) @(negedge clk);
      total++; if (tx_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b want=1", tx_err); end
      stub_mode = 0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL to_clear got=%b want=0", tx_err); end
   endtask

   task automatic test_underrun();
      logic [7:0] a = 8'($urandom);
      logic [7:0] b = 8'($urandom);
      int  n = 0;
      bit  ok;
      cap.delete(); exp.delete();
      exp.push_back(8'h7E); exp.push_back(a);
      push_byte(a, 1'b0);
      while (!(cap.size() >= 2 && !tx_busy) && n < 2000) begin @(negedge clk); n++; end
      repeat (50) @(negedge clk);
      total++; if (frame_diffs() != 0) begin bad++; $display("FAIL ur_partial: got %0d bytes want %0d diffs=%0d", cap.size(), exp.size(), frame_diffs()); end
      total++; if (frame_active !== 1'b1) begin bad++; $display("FAIL ur_active got=%b want=1", frame_active); end
      exp.push_back(b);
`ifdef UART_TX_CHECKSUM_EN
      exp.push_back(a ^ b);
`endif
      push_byte(b, 1'b1);
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("FAIL ur_idle: got=0 want=1"); end
      total++; if (frame_diffs() != 0) begin bad++; $display("FAIL ur_frame: got %0d bytes want %0d diffs=%0d", cap.size(), exp.size(), frame_diffs()); end
   endtask

   task automatic test_reset_mid();
      bq_t pkt;
      int  n = 0;
      bit  ok;
      cap.delete(); exp.delete();
      for (int i = 0; i < 6; i++) push_byte(8'($urandom), i == 5);
      while (cap.size() < 3 && n < 3000) begin @(negedge clk); n++; end
      @(negedge clk); rst = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b want=0", in_ready); end
      @(posedge clk); #1;
      total++; if (tx_start !== 1'b0 || fifo_count !== 5'd0 || frame_active !== 1'b0) begin
         bad++; $display("FAIL mid_rst: tx_start=%b count=%0d active=%b want 0/0/0", tx_start, fifo_count, frame_active);
      end
      @(negedge clk); rst = 1'b0;
      n = 0;
      while (tx_busy && n < 200) begin @(negedge clk); n++; end
      cap.delete(); exp.delete();
      pkt.push_back(8'($urandom)); pkt.push_back(8'($urandom));
      add_expected(pkt);
      push_byte(pkt[0], 1'b0);
      push_byte(pkt[1], 1'b1);
      wait_idle(ok);
      total++; if (!ok || frame_diffs() != 0) begin bad++; $display("FAIL mid_new_frame: idle=%b got %0d bytes want %0d diffs=%0d", ok, cap.size(), exp.size(), frame_diffs()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_timeout();
      test_underrun();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
